// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate test sequencer: FSM states, vector count
// and the Gray-ordered {A,B,C} stimulus table.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int N_VEC = 8;

    // Gray order means that only one gate input toggles between consecutive vectors
    localparam logic [2:0] GRAY_VEC [N_VEC] = '{
        3'b000, 3'b001, 3'b011, 3'b010,
        3'b110, 3'b111, 3'b101, 3'b100
    };

    function automatic logic [2:0] grayVec(input logic [2:0] idx);
        return GRAY_VEC[idx];
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Golden combinational model of the gate under test: Y = A&B | B&C.
module gate_ref_model (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic Y_exp
);

    assign Y_exp = (A & B) | (B & C);

endmodule

// File: rtl/gate_test_seq.sv
// Exhaustive Gray-order tester for a 3-input gate; counts mismatches (saturating).
// Optional first-failure capture is enabled by defining GATE_TEST_FIRST_FAIL_EN.
module gate_test_seq
    import gate_test_pkg::*;
#(
    parameter int HOLD_CYCLES = 5,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Y_in,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic [2:0]       vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef GATE_TEST_FIRST_FAIL_EN
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [2:0]       fail_vec
`else
    output logic [ERR_W-1:0] err_cnt
`endif
);

    localparam logic [7:0]       LAST_HOLD = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0]       LAST_VEC  = 3'(N_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t           state_q;
    logic [2:0]       vecIdx_q;
    logic [7:0]       hold_q;
    logic             a_q, b_q, c_q;
    logic             busy_q, done_q;
    logic [ERR_W-1:0] errCnt_q;

    logic             yExp;
    logic             startAcc_d;
    logic             lastHold_d;
    logic             mismatch_d;
    logic [ERR_W-1:0] errCnt_d;
    logic [2:0]       nextVec_d;

    gate_ref_model uRefModel (
        .A     (a_q),
        .B     (b_q),
        .C     (c_q),
        .Y_exp (yExp)
    );

    // The gate output is only trusted after it has settled for the full hold window
    assign startAcc_d = start && (state_q != DRIVE);
    assign lastHold_d = (hold_q == LAST_HOLD);
    assign mismatch_d = (state_q == DRIVE) && lastHold_d && (Y_in != yExp);
    assign errCnt_d   = (mismatch_d && (errCnt_q != ERR_MAX)) ? errCnt_q + ERR_W'(1) : errCnt_q;
    assign nextVec_d  = grayVec(vecIdx_q + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vecIdx_q <= '0;
            hold_q   <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            errCnt_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q         <= DRIVE;
                        vecIdx_q        <= '0;
                        hold_q          <= '0;
                        {a_q, b_q, c_q} <= grayVec(3'd0);
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                        errCnt_q        <= '0;
                    end
                end
                DRIVE: begin
                    errCnt_q <= errCnt_d;
                    if (lastHold_d) begin
                        hold_q <= '0;
                        if (vecIdx_q == LAST_VEC) begin
                            state_q         <= DONE;
                            vecIdx_q        <= '0;
                            {a_q, b_q, c_q} <= 3'b000;
                            busy_q          <= 1'b0;
                            done_q          <= 1'b1;
                        end else begin
                            vecIdx_q        <= vecIdx_q + 3'd1;
                            {a_q, b_q, c_q} <= nextVec_d;
                        end
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef GATE_TEST_FIRST_FAIL_EN
    logic       failValid_q;
    logic [2:0] failVec_q;

    // Only the first mismatch of a run is kept; later ones leave the capture alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            failValid_q <= 1'b0;
            failVec_q   <= '0;
        end else if (startAcc_d) begin
            failValid_q <= 1'b0;
            failVec_q   <= '0;
        end else if (mismatch_d && !failValid_q) begin
            failValid_q <= 1'b1;
            failVec_q   <= {a_q, b_q, c_q};
        end
    end

    assign fail_valid = failValid_q;
    assign fail_vec   = failVec_q;
`else
    logic unusedStartAcc;
    assign unusedStartAcc = startAcc_d;
`endif

    assign A       = a_q;
    assign B       = b_q;
    assign C       = c_q;
    assign vec_idx = vecIdx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = errCnt_q;
    assign pass    = done_q && (errCnt_q == '0);

endmodule
